// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// The CSUM state only exists when BOOT_LOADER_CHECKSUM_EN is defined.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WFLUSH,
`ifdef BOOT_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word_vld marks the 4th byte (same cycle, combinational).
// No backpressure of its own: byte_vld must only be raised for bytes the loader has accepted.
module byte_word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam int IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int PART_W = 8 * (BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PART_W-1:0] part_q, part_d;

  always_comb begin
    idx_d    = idx_q;
    part_d   = part_q;
    word_vld = byte_vld && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    word_dat = {byte_dat, part_q};
    if (byte_vld) begin
      idx_d  = idx_q + IDX_W'(1);
      // Each new byte enters the top lane, so after three bytes b0 sits lowest.
      part_d = {byte_dat, part_q[PART_W-1:8]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      part_q <= '0;
    end else begin
      idx_q  <= idx_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases core_reset; write strobe lags the 4th byte by one cycle.
// in_ready depends on state only (low in WFLUSH/DONE/ERROR). Optional trailing checksum: BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 256,
  parameter int ADDR_W           = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam int               LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(IMEM_DEPTH_WORDS);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CSUM;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;
  logic              word_vld;
  logic [31:0]       word_dat;
  logic [LEN_W-1:0]  len_full;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};

  byte_word_assembler u_asm (
    .clock    (clock),
    .reset    (reset),
    .byte_vld (accept && (state_q == ST_DATA)),
    .byte_dat (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    in_ready = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_LEN0: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d = len_full;
          if (len_full > DEPTH)       state_d = ST_ERROR;
          else if (len_full == '0)    state_d = ST_TAIL;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (word_vld) begin
          we_d    = 1'b1;
          wdata_d = word_dat;
          addr_d  = ADDR_W'({cnt_q, 2'b00});
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = ST_WFLUSH;
        end
      end
      // Last write is on the bus during this cycle; release waits until it lands.
      ST_WFLUSH: state_d = ST_TAIL;
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: ;
    endcase
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (accept && (state_q inside {ST_LEN0, ST_LEN1, ST_DATA})) csum_d = csum_q ^ in_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LEN0;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: vector table, hand-written corner sequences and randomized streams vs a stream-parsing model.
module tb_boot_loader;

  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, core_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  typedef struct packed {
    logic [79:0] b;
    logic [7:0]  nb;
    logic [7:0]  gap;
    logic        e_done;
    logic        e_err;
    logic [7:0]  e_nwr;
  } vec_t;

  vec_t tbl[6];

  boot_loader #(.IMEM_DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write monitor: captures every strobe and checks strobe spacing and reset hold.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      chk("we_back_to_back", {63'b0, prev_we}, 64'd0);
      chk("core_reset_during_write", {63'b0, core_reset}, 64'd1);
    end
    prev_we = (imem_we === 1'b1);
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wr_q.delete();
  endtask

  // Drives stim_q with random idle gaps; gives up on the rest of the stream if in_ready stays low.
  task automatic send(input int gap_pct);
    int w;
    for (int i = 0; i < stim_q.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      w = 0;
      while (in_ready !== 1'b1 && w < 3) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
        w++;
      end
      if (in_ready !== 1'b1) begin
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (stim_q[i]) x ^= stim_q[i];
    return x;
  endfunction

  // Reference: parse the stream as a whole and list the writes it should produce.
  task automatic model(output logic m_done, output logic m_err);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({stim_q[1], stim_q[0]});
    if (n > DEPTH) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++)
      exp_q.push_back({32'(w * 4), stim_q[2+4*w+3], stim_q[2+4*w+2], stim_q[2+4*w+1], stim_q[2+4*w]});
`ifdef BOOT_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= stim_q[i];
    m_done = (stim_q.size() > 2 + 4 * n) && (stim_q[2+4*n] == x);
    m_err  = !m_done;
`else
    x = 8'h00;
    m_done = 1'b1;
    m_err  = (x != 8'h00);
`endif
  endtask

  task automatic run_stream(input string tag, input int gap_pct, output logic m_done, output logic m_err);
    do_reset();
    send(gap_pct);
    repeat (3) @(posedge clock);
    #1;
    model(m_done, m_err);
    chk({tag, "_done"}, {63'b0, done}, {63'b0, m_done});
    chk({tag, "_error"}, {63'b0, error}, {63'b0, m_err});
    chk({tag, "_core_reset"}, {63'b0, core_reset}, {63'b0, !m_done});
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd0);
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) chk({tag, "_write"}, wr_q[i], exp_q[i]);
      else checks++;
  endtask

  task automatic load_bytes(input logic [7:0] b[$]);
    stim_q = b;
  endtask

  initial begin
    logic md, me;
    logic [7:0] tmp;
    int n;

    tbl[0] = '{80'h0010_0193_0000_0113_0002, 8'd10, 8'd0,  1'b1, 1'b0, 8'd2};
    tbl[1] = '{80'h0010_0193_0000_0113_0002, 8'd10, 8'd50, 1'b1, 1'b0, 8'd2};
    tbl[2] = '{80'h0000,                     8'd2,  8'd0,  1'b1, 1'b0, 8'd0};
    tbl[3] = '{80'h012C,                     8'd2,  8'd0,  1'b0, 1'b1, 8'd0};
    tbl[4] = '{80'h0101,                     8'd2,  8'd0,  1'b0, 1'b1, 8'd0};
    tbl[5] = '{80'h1234_5678_0001,           8'd6,  8'd30, 1'b1, 1'b0, 8'd1};

    // Reset values
    do_reset();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_we", {63'b0, imem_we}, 64'd0);
    chk("rst_addr", {32'b0, imem_addr}, 64'd0);
    chk("rst_wdata", {32'b0, imem_wdata}, 64'd0);
    chk("rst_core_reset", {63'b0, core_reset}, 64'd1);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_error", {63'b0, error}, 64'd0);

    // Vector table
    for (int k = 0; k < 6; k++) begin
      stim_q.delete();
      for (int i = 0; i < int'(tbl[k].nb); i++) stim_q.push_back(tbl[k].b[8*i +: 8]);
`ifdef BOOT_LOADER_CHECKSUM_EN
      tmp = xor_all();
      stim_q.push_back(tmp);
`endif
      run_stream($sformatf("vec%0d", k), int'(tbl[k].gap), md, me);
      chk($sformatf("vec%0d_tbl_done", k), {63'b0, done}, {63'b0, tbl[k].e_done});
      chk($sformatf("vec%0d_tbl_error", k), {63'b0, error}, {63'b0, tbl[k].e_err});
      chk($sformatf("vec%0d_tbl_nwr", k), 64'(wr_q.size()), {56'b0, tbl[k].e_nwr});
      if (k == 0) begin
        chk("n2_word0", wr_q.size() > 0 ? wr_q[0] : 64'hX, {32'h0, 32'h0000_0113});
        chk("n2_word1", wr_q.size() > 1 ? wr_q[1] : 64'hX, {32'h4, 32'h0010_0193});
      end
    end

    // Release timing: final strobe in WFLUSH with core still in reset
    load_bytes('{8'h02, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00});
    do_reset();
    send(0);
    chk("rel_last_we", {63'b0, imem_we}, 64'd1);
    chk("rel_last_addr", {32'b0, imem_addr}, 64'd4);
    chk("rel_last_core_reset", {63'b0, core_reset}, 64'd1);
    chk("rel_wflush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clock); #1;
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("rel_csum_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rel_csum_done", {63'b0, done}, 64'd0);
`else
    chk("rel_done", {63'b0, done}, 64'd1);
    chk("rel_core_reset", {63'b0, core_reset}, 64'd0);
`endif

    // Reset mid-word, with a byte offered on the reset edge, then a fresh N=1 stream
    load_bytes('{8'h02, 8'h00, 8'h13, 8'h01});
    do_reset();
    send(0);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_core_reset", {63'b0, core_reset}, 64'd1);
    wr_q.delete();
    load_bytes('{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
`ifdef BOOT_LOADER_CHECKSUM_EN
    tmp = xor_all();
    stim_q.push_back(tmp);
`endif
    send(0);
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_nwr", 64'(wr_q.size()), 64'd1);
    chk("midrst_word", wr_q.size() > 0 ? wr_q[0] : 64'hX, {32'h0, 32'hEFBE_ADDE});
    chk("midrst_done", {63'b0, done}, 64'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    load_bytes('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01});
    run_stream("csum_ok", 0, md, me);
    chk("csum_ok_done", {63'b0, done}, 64'd1);
    load_bytes('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02});
    run_stream("csum_bad", 0, md, me);
    chk("csum_bad_error", {63'b0, error}, 64'd1);
    chk("csum_bad_core_reset", {63'b0, core_reset}, 64'd1);
    chk("csum_bad_word", wr_q.size() > 0 ? wr_q[0] : 64'hX, {32'h0, 32'hDDCC_BBAA});
`endif

    // Randomized streams, including the full-depth boundary
    for (int r = 0; r < 24; r++) begin
      stim_q.delete();
      if (r == 0) n = DEPTH;
      else if ($urandom_range(4) == 0) n = int'($urandom_range(65535, DEPTH + 1));
      else n = int'($urandom_range(8, 1));
      stim_q.push_back(8'(n));
      stim_q.push_back(8'(n >> 8));
      if (n <= DEPTH) for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
`ifdef BOOT_LOADER_CHECKSUM_EN
      tmp = xor_all();
      if ($urandom_range(3) == 0) tmp = tmp ^ 8'(1 << $urandom_range(7));
      stim_q.push_back(tmp);
`endif
      run_stream($sformatf("rnd%0d", r), int'($urandom_range(40)), md, me);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
